// File: rtl/matrix_issue_ctrl.sv
// Matrix instruction issue controller: decodes an opcode into register-file
// port selects, holds them until downstream accepts, and stalls issue while a
// multi-cycle MMUL or IDIV/IDIVI occupies the execution unit.
module matrix_issue_ctrl #(
    parameter int unsigned NREG    = 3,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [5:0]                   op,
    input  logic [$clog2(NREG)-1:0]      rin1,
    input  logic [$clog2(NREG)-1:0]      rin2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NREG+1)-1:0]    src1,
    output logic [$clog2(NREG+2)-1:0]    src2,
    output logic [5:0]                   op_q,
    output logic                         illegal,
    output logic                         busy
);

    localparam int unsigned RW = $clog2(NREG);
    localparam int unsigned W1 = $clog2(NREG + 1);
    localparam int unsigned W2 = $clog2(NREG + 2);
    localparam int unsigned CW = 8;

    localparam logic [5:0] OP_MLD   = 6'b000000;
    localparam logic [5:0] OP_MSTR  = 6'b000001;
    localparam logic [5:0] OP_MADD  = 6'b001000;
    localparam logic [5:0] OP_MSUB  = 6'b001001;
    localparam logic [5:0] OP_MMUL  = 6'b001100;
    localparam logic [5:0] OP_SMUL  = 6'b001101;
    localparam logic [5:0] OP_MCMP  = 6'b011000;
    localparam logic [5:0] OP_ICMP  = 6'b011001;
    localparam logic [5:0] OP_ZERO  = 6'b100100;
    // Integer divides live in the no-operand 010xxx group
    localparam logic [5:0] OP_IDIV  = 6'b010000;
    localparam logic [5:0] OP_IDIVI = 6'b010001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            accept;
    logic            held_multi;
    logic [W1-1:0]   dec_src1;
    logic [W2-1:0]   dec_src2;
    logic            dec_ill;
    logic            r1_bad, r2_bad;

    assign r1_bad = (32'(rin1) >= NREG);
    assign r2_bad = (32'(rin2) >= NREG);

    // A legal held MMUL/IDIV/IDIVI must drain through BUSY before new issue
    assign held_multi = !illegal &&
                        ((op_q == OP_MMUL) || (op_q == OP_IDIV) || (op_q == OP_IDIVI));

    // Opcode and index decode into register-file selects
    always_comb begin
        dec_src1 = '0;
        dec_src2 = '0;
        dec_ill  = 1'b0;
        casez (op)
            OP_MADD, OP_MSUB, OP_MMUL, OP_MCMP: begin
                if (r1_bad || r2_bad) begin
                    dec_ill = 1'b1;
                end else begin
                    dec_src1 = W1'(rin1);
                    dec_src2 = W2'(rin2) + W2'(1);
                end
            end
            OP_SMUL, OP_ICMP: begin
                if (r1_bad) begin
                    dec_ill = 1'b1;
                end else begin
                    dec_src1 = W1'(rin1);
                    dec_src2 = W2'(NREG + 1);
                end
            end
            OP_ZERO: begin
                if (r1_bad) begin
                    dec_ill = 1'b1;
                end else begin
                    dec_src1 = W1'(rin1);
                end
            end
            OP_MLD: begin
                dec_src1 = W1'(NREG);
                dec_src2 = W2'(1);
            end
            OP_MSTR: begin
                dec_src1 = W1'(NREG);
            end
            6'b010???, 6'b0111??: begin
                dec_src1 = '0;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

    // Next state, busy counter and issue handshake
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                in_ready = out_ready && !held_multi;
                if (out_ready) begin
                    if (held_multi) begin
                        state_nxt = BUSY;
                        cnt_nxt   = (op_q == OP_MMUL) ? CW'(MUL_LAT - 1) : CW'(DIV_LAT - 1);
                    end else if (in_valid) begin
                        accept    = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered outputs; selects change only when an instruction is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src1      <= '0;
            src2      <= '0;
            op_q      <= '0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_valid <= (state_nxt == HOLD);
            busy      <= (state_nxt == BUSY);
            if (accept) begin
                src1    <= dec_src1;
                src2    <= dec_src2;
                op_q    <= op;
                illegal <= dec_ill;
            end
        end
    end

endmodule
